// File: rtl/ibuf_pkg.sv
// ----------------------------------------------------------------------------
// ibuf_pkg
// Shared types and helpers for the ping-pong skewed input buffer.
//   bank_state_t : lifecycle of one bank (EMPTY -> FILLING -> FULL -> DRAINING)
//   ibuf_dbg_t   : debug snapshot of the bank-tracking state machine
//   lane_slice() : low bit index of lane i inside a packed lane vector
// ----------------------------------------------------------------------------
package ibuf_pkg;

  localparam int ARRAY_SIZE_DEF = 8;
  localparam int ELEM_W_DEF     = 8;
  localparam int DEPTH_DEF      = 32;
  localparam int LOG_DEPTH_DEF  = 5;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  typedef struct packed {
    bank_state_t state1;
    bank_state_t state0;
    logic        wr_bank;
    logic        rd_bank;
  } ibuf_dbg_t;

  // Lane i occupies bits [lane_slice(i) +: elem_w] of a packed vector.
  function automatic int lane_slice(input int i, input int elem_w = ELEM_W_DEF);
    return i * elem_w;
  endfunction

endpackage

// File: rtl/ibuf_skew_pp_bank.sv
// ----------------------------------------------------------------------------
// ibuf_bank
// One bank of the ping-pong buffer: ARRAY_SIZE independent lane memories,
// each ELEM_W wide and DEPTH deep, with one shared write port and one read
// port per lane.
//   clk, rst_n : clock; rst_n clears only the read registers, not the memory
//   wr_en      : write all lanes of wr_data at wr_addr
//   wr_addr    : write address shared by all lanes
//   wr_data    : packed lane vector to store
//   rd_en      : per-lane read enable; a disabled lane registers zero
//   rd_addr    : per-lane read addresses, packed LOG_DEPTH bits per lane
//   rd_data    : registered per-lane read data (one cycle latency)
// ----------------------------------------------------------------------------
module ibuf_bank
  import ibuf_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int ELEM_W     = ELEM_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOG_DEPTH  = LOG_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [LOG_DEPTH-1:0]         wr_addr,
  input  logic [ARRAY_SIZE*ELEM_W-1:0] wr_data,
  input  logic [ARRAY_SIZE-1:0]        rd_en,
  input  logic [ARRAY_SIZE*LOG_DEPTH-1:0] rd_addr,
  output logic [ARRAY_SIZE*ELEM_W-1:0] rd_data
);

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [ELEM_W-1:0]    mem [DEPTH];
    logic [ELEM_W-1:0]    q;
    logic [LOG_DEPTH-1:0] addr;

    assign addr = rd_addr[i*LOG_DEPTH +: LOG_DEPTH];

    // Storage array kept free of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data[lane_slice(i, ELEM_W) +: ELEM_W];
      end
    end

    // Zero when not enabled: this is what produces the skew padding and
    // keeps the output at zero whenever no drain is issuing.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q <= '0;
      end else if (rd_en[i]) begin
        q <= mem[addr];
      end else begin
        q <= '0;
      end
    end

    assign rd_data[lane_slice(i, ELEM_W) +: ELEM_W] = q;
  end

endmodule

// File: rtl/ibuf_skew_pp.sv
// ----------------------------------------------------------------------------
// ibuf_skew_pp
// Ping-pong input buffer for the systolic array rows. The writer fills one
// bank with lane vectors while the reader drains the other bank with a
// diagonal skew: lane i is delayed by i cycles and padded with zeros.
//
// Handshake: a write is accepted on a cycle where wr_valid && wr_ready;
// wr_last is only meaningful on an accepted write. The DEPTH-th write
// finalises the bank even without wr_last. rd_start is a request, not a
// valid/ready pair: it is taken only when rd_busy=0 and the oldest bank is
// FULL, and is otherwise dropped. The read side has no backpressure.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   wr_valid, wr_ready, wr_data, wr_last : write vector stream
//   rd_start   : request drain of the oldest FULL bank
//   rd_busy    : drain in progress
//   rd_valid, rd_data : skewed output vectors (rd_data is zero when !rd_valid)
//   rd_done    : pulse with the final rd_valid of a drain
//   dbg        : bank states and bank pointers
// ----------------------------------------------------------------------------
module ibuf_skew_pp
  import ibuf_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int ELEM_W     = ELEM_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOG_DEPTH  = LOG_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ARRAY_SIZE*ELEM_W-1:0] wr_data,
  input  logic                         wr_last,
  input  logic                         rd_start,
  output logic                         rd_busy,
  output logic                         rd_valid,
  output logic [ARRAY_SIZE*ELEM_W-1:0] rd_data,
  output logic                         rd_done,
  output ibuf_dbg_t                    dbg
);

  localparam int VEC_W  = ARRAY_SIZE * ELEM_W;
  localparam int CNT_W  = LOG_DEPTH + 1;
  localparam int STEP_W = $clog2(DEPTH + ARRAY_SIZE);

  bank_state_t          bank_state [2];
  logic [CNT_W-1:0]     bank_n     [2];
  logic                 wr_bank;
  logic                 rd_bank;
  logic [LOG_DEPTH-1:0] wr_cnt;
  logic                 rd_issue;   // a drain step is being issued this cycle
  logic [STEP_W-1:0]    step;

  logic                 wr_fire;
  logic                 wr_fin;
  logic                 rd_go;
  logic                 last_step;
  logic [CNT_W-1:0]     drain_n;
  logic [ARRAY_SIZE-1:0]           lane_en;
  logic [ARRAY_SIZE*LOG_DEPTH-1:0] lane_addr;
  logic [VEC_W-1:0]     bank_q [2];

  assign wr_ready  = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_fin    = wr_fire && (wr_last || (wr_cnt == LOG_DEPTH'(DEPTH - 1)));
  assign rd_go     = rd_start && !rd_busy && (bank_state[rd_bank] == FULL);
  assign drain_n   = bank_n[rd_bank];
  // Steps run 0 .. N+ARRAY_SIZE-2 so the last lane sees its final element.
  assign last_step = rd_issue && (int'(step) == int'(drain_n) + ARRAY_SIZE - 2);

  // Lane i at step t reads element t-i; outside 0..N-1 the lane is padded.
  always_comb begin
    int d;
    d         = 0;
    lane_en   = '0;
    lane_addr = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      d          = int'(step) - i;
      lane_en[i] = rd_issue && (d >= 0) && (d < int'(drain_n));
      lane_addr[i*LOG_DEPTH +: LOG_DEPTH] = LOG_DEPTH'(d);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ibuf_bank #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .ELEM_W     (ELEM_W),
      .DEPTH      (DEPTH),
      .LOG_DEPTH  (LOG_DEPTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_fire && (wr_bank == 1'(b))),
      .wr_addr (wr_cnt),
      .wr_data (wr_data),
      .rd_en   ((rd_bank == 1'(b)) ? lane_en : '0),
      .rd_addr (lane_addr),
      .rd_data (bank_q[b])
    );
  end

  // Only the draining bank ever enables reads, so the idle bank's output
  // register is zero and a plain OR merges the two banks.
  assign rd_data = bank_q[0] | bank_q[1];

  // Bank tracking. Writer and reader never touch the same bank in the same
  // cycle: writes need EMPTY/FILLING, rd_go needs FULL, release needs DRAINING.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      bank_n[0]     <= '0;
      bank_n[1]     <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_busy       <= 1'b0;
      rd_issue      <= 1'b0;
      step          <= '0;
      rd_valid      <= 1'b0;
      rd_done       <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_fin) begin
          bank_state[wr_bank] <= FULL;
          bank_n[wr_bank]     <= {1'b0, wr_cnt} + CNT_W'(1);
          wr_cnt              <= '0;
          wr_bank             <= ~wr_bank;
        end else begin
          bank_state[wr_bank] <= FILLING;
          wr_cnt              <= wr_cnt + LOG_DEPTH'(1);
        end
      end

      // Output flags trail the issued step by the one-cycle read latency.
      rd_valid <= rd_issue;
      rd_done  <= last_step;

      if (rd_go) begin
        rd_busy             <= 1'b1;
        rd_issue            <= 1'b1;
        step                <= '0;
        bank_state[rd_bank] <= DRAINING;
      end else if (rd_issue) begin
        if (last_step) begin
          rd_issue <= 1'b0;
        end else begin
          step <= step + STEP_W'(1);
        end
      end

      // Release one cycle after the final output so the bank is writable
      // in the same cycle rd_busy drops.
      if (rd_done) begin
        rd_busy             <= 1'b0;
        bank_state[rd_bank] <= EMPTY;
        rd_bank             <= ~rd_bank;
      end
    end
  end

  always_comb begin
    dbg         = '0;
    dbg.state0  = bank_state[0];
    dbg.state1  = bank_state[1];
    dbg.wr_bank = wr_bank;
    dbg.rd_bank = rd_bank;
  end

endmodule
